// File: rtl/gps_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter between
// several byte-stream requesters.
//
// Once a requester is granted, it owns the transmitter until its byte flagged
// last has been sent. Each byte is started with a one-cycle tx_dv pulse, and
// the arbiter then waits for tx_done. If the owner stalls mid-packet for too
// long, the grant is released and abort pulses. After every packet, and after
// every abort, GAP_CYCLES idle clocks pass before the next arbitration.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   req        per-requester byte valid, held with data until acked
//   req_data   byte of requester i on bits [8i+7:8i]
//   req_last   presented byte is the final byte of its packet
//   req_ack    one-cycle pulse: byte of requester i accepted
//   grant      one-hot current owner, zero when unowned
//   tx_data    byte to the UART TX
//   tx_dv      one-cycle start pulse to the UART TX
//   tx_active  UART TX busy serialising
//   tx_done    one-cycle pulse: UART TX finished the byte
//   abort      one-cycle pulse when a grant is released by timeout
//   busy       high in every state except idle
module gps_uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_dv,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic                 abort,
    output logic                 busy
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitDone, StGap} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_dv_q, tx_dv_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;
    logic               last_q, last_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;

    // The search starts just past the previous winner, so the requester that
    // was served last gets the lowest priority.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        req_ack_d = '0;
        tx_data_d = tx_data_q;
        tx_dv_d   = 1'b0;
        abort_d   = 1'b0;
        last_d    = last_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    grant_d  = NUM_REQ'(1) << win_idx;
                    ptr_d    = win_idx;
                    to_cnt_d = '0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                // While the UART is busy, a stalled owner is not penalised.
                if (!tx_active) begin
                    if (req[ptr_q]) begin
                        tx_data_d       = 8'(req_data >> {ptr_q, 3'b000});
                        tx_dv_d         = 1'b1;
                        req_ack_d[ptr_q] = 1'b1;
                        last_d          = req_last[ptr_q];
                        to_cnt_d        = '0;
                        state_d         = StWaitDone;
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_d   = 1'b1;
                        grant_d   = '0;
                        to_cnt_d  = '0;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    if (last_q) begin
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            grant_q   <= '0;
            req_ack_q <= '0;
            tx_data_q <= '0;
            tx_dv_q   <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            req_ack_q <= req_ack_d;
            tx_data_q <= tx_data_d;
            tx_dv_q   <= tx_dv_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign req_ack = req_ack_q;
    assign tx_data = tx_data_q;
    assign tx_dv   = tx_dv_q;
    assign abort   = abort_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_gps_uart_tx_arbiter.sv
// Bench for gps_uart_tx_arbiter. Requesters are modelled as byte queues, and
// the UART TX is modelled by a done-delay counter. A transaction-level monitor
// checks the following against the arbitration rules:
//   - every round-robin grant,
//   - every acked byte,
//   - every grant release.
// Directed sequences then check exact latencies, the gap length, the timeout
// and the reset behaviour, and a randomized phase follows.
module tb_gps_uart_tx_arbiter;
    localparam int NR  = 4;
    localparam int GAP = 2;
    localparam int TO  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic [7:0]      tx_data;
    logic            tx_dv;
    logic            tx_active;
    logic            tx_done;
    logic            abort;
    logic            busy;

    gps_uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_data  (tx_data),
        .tx_dv    (tx_dv),
        .tx_active(tx_active),
        .tx_done  (tx_done),
        .abort    (abort),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Requester model: {last, data} byte queues.
    logic [8:0] stream [NR][64];
    int         head [NR];
    int         tail [NR];
    bit         en [NR];
    int         start_cyc [NR];

    // UART model.
    int u_cnt;
    int u_delay;
    bit u_busy;
    bit force_active;
    bit rand_delay;
    bit spur_en;

    // Arbitration reference state.
    int            m_ptr;
    int            m_owner;
    bit            m_last;
    logic [NR-1:0] prev_grant;
    int            zero_run;
    int            n_abort = 0;
    int            n_ack   = 0;
    int            gr_log [64];
    int            gz_log [64];
    int            gr_n    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
        int res = -1;
        for (int k = 1; k <= NR; k++) begin
            if (res < 0 && r[(ptr + k) % NR]) res = (ptr + k) % NR;
        end
        return res;
    endfunction

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (head[i] < tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (en[i] && head[i] < tail[i]) begin
                req[i]              = 1'b1;
                req_data[8*i +: 8]  = stream[i][head[i]][7:0];
                req_last[i]         = stream[i][head[i]][8];
            end else begin
                req[i]      = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input bit last);
        if (head[r] == tail[r]) begin
            head[r] = 0;
            tail[r] = 0;
        end
        stream[r][tail[r]] = {last, d};
        tail[r]++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            head[i]      = 0;
            tail[i]      = 0;
            en[i]        = 1'b1;
            start_cyc[i] = 0;
        end
        u_busy       = 1'b0;
        u_cnt        = 0;
        tx_done      = 1'b0;
        force_active = 1'b0;
        tx_active    = 1'b0;
        m_ptr        = NR - 1;
        m_owner      = -1;
        m_last       = 1'b0;
        prev_grant   = '0;
        zero_run     = 1000;
        req_data     = '0;
        drive_reqs();
    endtask

    task automatic monitor();
        int            w;
        logic [NR-1:0] e;
        if (grant !== prev_grant) begin
            check_eq("grant_onehot", $countones(grant) <= 1, 1);
            if (prev_grant == '0) begin
                w = rr_pick(m_ptr, req);
                e = '0;
                if (w >= 0) e[w] = 1'b1;
                check_eq("rr_grant", grant, e);
                check_eq("gap_min", zero_run >= GAP + 1, 1);
                gr_log[gr_n % 64] = w;
                gz_log[gr_n % 64] = zero_run;
                gr_n++;
                if (w >= 0) m_ptr = w;
                m_owner = w;
            end else begin
                check_eq("release_ok", (grant == '0) && (abort || (tx_done && m_last)), 1);
                m_owner = -1;
            end
        end
        if (abort) n_abort++;
        if (tx_dv || req_ack != '0) check_eq("dv_ack_pair", tx_dv, req_ack != '0);
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i]) begin
                n_ack++;
                check_eq("ack_owner", i, m_owner);
                check_eq("ack_pending", en[i] && head[i] < tail[i], 1);
                if (head[i] < tail[i]) begin
                    check_eq("ack_data", tx_data, stream[i][head[i]][7:0]);
                    m_last = stream[i][head[i]][8];
                end
            end
        end
        if (grant == '0) zero_run++;
        else zero_run = 0;
        prev_grant = grant;
    endtask

    task automatic uart_step();
        tx_done = 1'b0;
        if (tx_dv) begin
            u_busy = 1'b1;
            u_cnt  = rand_delay ? int'($urandom_range(1, 8)) : u_delay;
        end else if (u_busy) begin
            u_cnt--;
            if (u_cnt == 0) begin
                tx_done = 1'b1;
                u_busy  = 1'b0;
            end
        end else if (spur_en && $urandom_range(0, 15) == 0) begin
            tx_done = 1'b1;  // stray pulse while no byte is in flight
        end
        tx_active = u_busy | force_active;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        for (int i = 0; i < NR; i++) if (req_ack[i] && head[i] < tail[i]) head[i]++;
        for (int i = 0; i < NR; i++) if (!en[i] && cyc >= start_cyc[i]) en[i] = 1'b1;
        uart_step();
        drive_reqs();
    endtask

    task automatic run_idle(input int max, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            tick();
            if (!busy && !any_pending() && !u_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, ok, 1);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        int  a0;
        int  g0;
        int  t_done;
        int  t_abort;
        int  bp_dv;
        int  bp_ab;
        int  tot;
        int  npk;
        int  len;
        bit  ok;
        bit  pre;

        rst        = 1'b0;
        u_delay    = 20;
        rand_delay = 1'b0;
        spur_en    = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_dv", tx_dv, 0);
        check_eq("rst_ack", req_ack, 0);
        check_eq("rst_abort", abort, 0);
        check_eq("rst_data", tx_data, 0);

        // Single requester, three-byte packet, minimum latency and gap length.
        a0 = n_ack;
        push_byte(0, 8'h24, 1'b0);
        push_byte(0, 8'h47, 1'b0);
        push_byte(0, 8'h50, 1'b1);
        drive_reqs();
        tick();
        check_eq("lat_grant", grant, 4'b0001);
        check_eq("lat_no_dv", tx_dv, 0);
        tick();
        check_eq("lat_dv", tx_dv, 1);
        check_eq("lat_ack", req_ack, 4'b0001);
        check_eq("lat_data", tx_data, 8'h24);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (grant == '0) begin
                ok = 1'b1;
                break;
            end
            check_eq("single_hold", grant, 4'b0001);
        end
        check_eq("single_release", ok, 1);
        check_eq("single_acks", n_ack - a0, 3);
        check_eq("gap_busy0", busy, 1);
        tick();
        check_eq("gap_busy1", busy, 1);
        tick();
        check_eq("gap_busy2", busy, 0);

        // Contention from reset: strict order 0..3, exact gap, then wrap to 0.
        u_delay = 3;
        do_reset();
        g0 = gr_n;
        for (int r = 0; r < NR; r++) begin
            push_byte(r, 8'($urandom_range(0, 255)), 1'b0);
            push_byte(r, 8'($urandom_range(0, 255)), 1'b1);
        end
        drive_reqs();
        run_idle(2000, "cont_drain");
        check_eq("cont_ngrant", gr_n - g0, NR);
        for (int k = 0; k < NR; k++) check_eq("cont_order", gr_log[(g0 + k) % 64], k);
        for (int k = 1; k < NR; k++) check_eq("cont_gap", gz_log[(g0 + k) % 64], GAP + 1);
        g0 = gr_n;
        for (int r = 0; r < NR; r++) push_byte(r, 8'($urandom_range(0, 255)), 1'b1);
        drive_reqs();
        run_idle(2000, "cont2_drain");
        check_eq("cont2_first", gr_log[g0 % 64], 0);

        // Wrap: pointer at 2 with 1 and 3 pending -> 3 before 1.
        push_byte(2, 8'h77, 1'b1);
        drive_reqs();
        run_idle(500, "wrap_pre");
        g0 = gr_n;
        push_byte(1, 8'h61, 1'b1);
        push_byte(3, 8'h63, 1'b1);
        drive_reqs();
        run_idle(500, "wrap_drain");
        check_eq("wrap_first", gr_log[g0 % 64], 3);
        check_eq("wrap_second", gr_log[(g0 + 1) % 64], 1);

        // Timeout: requester 2 stalls after a non-last byte.
        push_byte(2, 8'h31, 1'b0);
        drive_reqs();
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("to_grant", grant, 4'b0100);
        push_byte(0, 8'hA5, 1'b1);
        drive_reqs();
        t_done  = -1;
        t_abort = -1;
        for (int k = 0; k < 200; k++) begin
            pre = tx_done;
            tick();
            if (pre) t_done = cyc;
            if (abort) begin
                t_abort = cyc;
                break;
            end
        end
        check_eq("to_seen", t_abort >= 0 && t_done >= 0, 1);
        check_eq("to_len", t_abort - t_done, TO);
        check_eq("to_grant_clr", grant, 0);
        g0 = gr_n;
        tick();
        check_eq("abort_pulse", abort, 0);
        run_idle(500, "to_drain");
        check_eq("to_next", gr_log[g0 % 64], 0);
        check_eq("to_next_gap", gz_log[g0 % 64], GAP + 1);

        // Backpressure: tx_active high while the owner waits in SEND.
        force_active = 1'b1;
        tx_active    = 1'b1;
        push_byte(1, 8'h5A, 1'b1);
        drive_reqs();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant != '0) break;
        end
        check_eq("bp_grant", grant, 4'b0010);
        bp_dv = 0;
        bp_ab = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (tx_dv) bp_dv++;
            if (abort) bp_ab++;
        end
        check_eq("bp_no_dv", bp_dv, 0);
        check_eq("bp_no_abort", bp_ab, 0);
        check_eq("bp_hold", grant, 4'b0010);
        force_active = 1'b0;
        tx_active    = u_busy;
        tick();
        check_eq("bp_launch", tx_dv, 1);
        run_idle(500, "bp_drain");

        // Asynchronous reset in the first WAIT_DONE cycle.
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b1);
        drive_reqs();
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (req_ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("ar_acked", ok, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_grant", grant, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_dv", tx_dv, 0);
        check_eq("ar_ack", req_ack, 0);
        clear_model();
        #2;
        rst = 1'b1;
        g0 = gr_n;
        push_byte(2, 8'h33, 1'b1);
        push_byte(0, 8'h44, 1'b1);
        drive_reqs();
        run_idle(500, "ar_drain");
        check_eq("ar_prio", gr_log[g0 % 64], 0);

        // Randomized traffic with staggered starts, random done delays, stray done pulses.
        a0         = n_ack;
        g0         = n_abort;
        rand_delay = 1'b1;
        spur_en    = 1'b1;
        tot        = 0;
        for (int r = 0; r < NR; r++) begin
            en[r]        = 1'b0;
            start_cyc[r] = cyc + int'($urandom_range(0, 40));
            npk          = int'($urandom_range(2, 4));
            for (int p = 0; p < npk; p++) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    push_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
                    tot++;
                end
            end
        end
        drive_reqs();
        run_idle(20000, "rand_drain");
        check_eq("rand_acks", n_ack - a0, tot);
        check_eq("rand_no_abort", n_abort - g0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gps_uart_tx_arbiter.md
Name: gps_uart_tx_arbiter

Overview:
Shares the single UART transmitter behind the GPS sentence path between several byte-stream requesters, e.g. the NMEA field echo, a status/heartbeat message generator and a debug dump. Grants are round-robin and packet-locked: a requester keeps the transmitter from its first byte through the byte flagged last. The block sequences each byte into the UART TX (start pulse, wait for done) and releases the grant on timeout if a requester stalls mid-packet.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle clocks inserted after every packet before the next arbitration (>=1)
TIMEOUT_CYCLES, 1000, clocks a granted requester may hold req low mid-packet before the grant is forcibly released (>=2)

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-low reset; all state clears while low
req  input  NUM_REQ  per-requester byte-valid; held with data until acked
req_data  input  8*NUM_REQ  byte from requester i on bits [8i+7:8i]
req_last  input  NUM_REQ  marks the presented byte as the packet's final byte
req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted
grant  output  NUM_REQ  one-hot current owner; all zero when unowned
tx_data  output  8  byte to the UART TX
tx_dv  output  1  one-cycle start pulse to the UART TX
tx_active  input  1  UART TX busy serialising
tx_done  input  1  one-cycle pulse: UART TX finished the byte (stop bit sent)
abort  output  1  one-cycle pulse when a grant is released by timeout
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst low, asynchronous): state is IDLE. grant, req_ack, tx_dv, abort, busy, tx_data and all counters are 0. The round-robin pointer is NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, SEND, WAIT_DONE, GAP. All outputs are registered.
- IDLE: if any req bit is high, select the first set bit searching upward from pointer+1 with modulo wrap. On the next edge set grant one-hot, set pointer to the winner, and go to SEND. No req means stay in IDLE.
- SEND (owner g):
  - If req[g]=1 and tx_active=0: on one edge load tx_data from slice g, pulse tx_dv and req_ack[g] together for exactly one cycle, latch req_last[g], clear the timeout counter, and go to WAIT_DONE.
  - If tx_active=1: wait; the timeout counter does not run.
  - If req[g]=0: increment the timeout counter. On reaching TIMEOUT_CYCLES, pulse abort, clear grant and go to GAP.
- WAIT_DONE: hold until tx_done. On tx_done, go to GAP with grant cleared if the latched last flag is 1, otherwise return to SEND. req_ack is never reasserted in this state.
- GAP: count GAP_CYCLES clocks with grant=0, then go to IDLE.
- Minimum latency: req rises at edge N in IDLE; grant at edge N+1; tx_dv/req_ack at edge N+2.
- Requester rule: after req_ack, the next byte may be presented on the following cycle. Non-owner requests are ignored, never acked and never dropped; they stay pending.
- Simultaneous tx_done with a new req: tx_done is handled first. The new byte is launched no earlier than one cycle after returning to SEND.
- A single-byte packet (req_last=1 on the first byte) is legal.
- tx_done outside WAIT_DONE is ignored.
- rst asserted mid-byte: outputs clear immediately. The UART TX is reset separately.

Test Plan:
- Single requester: req[0] sends 0x24,0x47,0x50 with last on 0x50, UART model 20-cycle done -> three tx_dv pulses carrying 0x24,0x47,0x50 in order, three req_ack[0] pulses, grant=0001 throughout, then grant=0 and 2 GAP cycles before IDLE.
- Contention: req[0..3] all raised the same cycle after reset, each sending a 2-byte packet -> grants in order 0001,0010,0100,1000. No interleaving of bytes within a packet. Next round starts at requester 0.
- Fairness/wrap: pointer=2 and req[1],req[3] pending -> requester 3 granted before 1.
- Timeout: req[2] sends 0x31 (not last) then drops req, TIMEOUT_CYCLES=16 -> abort pulses exactly 16 clocks after the first low cycle in SEND, grant clears, and pending req[0] is granted after the GAP.
- Backpressure: tx_active held high for 50 cycles in SEND -> no tx_dv, no abort, byte launched the cycle after tx_active falls.
- Async reset: rst driven low during WAIT_DONE between clock edges -> grant, busy, tx_dv and req_ack go to 0 without a clock edge. After release, requester 0 has priority.
